// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment frame decoder.
// Segment patterns are bits g..a; codes are the recovered 4-bit digit values.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HAVE_ONES = 2'd1,
    HAVE_TENS = 2'd2
  } frame_state_e;

endpackage

// File: rtl/seg_frame_decoder_if.sv
// Display bus plus recovered-frame outputs of the segment frame decoder.
// master = bus driver / consumer of results, slave = the decoder itself.
interface seg_frame_decoder_if;
  logic [7:0] seg_in;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       tens_err;
  logic       ones_err;
  logic       frame_valid;
  logic       stale;

  modport master (
    output seg_in,
    input  tens, ones, tens_err, ones_err, frame_valid, stale
  );

  modport slave (
    input  seg_in,
    output tens, ones, tens_err, ones_err, frame_valid, stale
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern to digit-code decoder.
// Blank maps to CODE_BLANK without error; unknown patterns map to CODE_ERR.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] code_o,
  output logic       err_o
);

  always_comb begin
    code_o = CODE_ERR;
    err_o  = 1'b0;
    case (pattern_i)
      SEG_0:     code_o = 4'd0;
      SEG_1:     code_o = 4'd1;
      SEG_2:     code_o = 4'd2;
      SEG_3:     code_o = 4'd3;
      SEG_4:     code_o = 4'd4;
      SEG_5:     code_o = 4'd5;
      SEG_6:     code_o = 4'd6;
      SEG_7:     code_o = 4'd7;
      SEG_8:     code_o = 4'd8;
      SEG_9:     code_o = 4'd9;
      SEG_BLANK: code_o = CODE_BLANK;
      default: begin
        code_o = CODE_ERR;
        err_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_frame_decoder.sv
// Recovers tens/ones digit codes from a multiplexed seven-segment bus,
// debouncing each bus value and pairing digits into complete frames.
//
// state     | meaning
// IDLE      | no digit pending
// HAVE_ONES | ones digit accepted, waiting for tens
// HAVE_TENS | tens digit accepted, waiting for ones
module seg_frame_decoder
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned TIMEOUT       = 16
)
(
  input  logic                clk,
  input  logic                rst_n,
  seg_frame_decoder_if.slave  bus
);

  localparam logic [3:0] RUN_MAX = 4'(STABLE_CYCLES);
  localparam logic [7:0] TO_MAX  = 8'(TIMEOUT);

  logic [7:0]   seg_q;
  logic [3:0]   run_q, run_d;
  logic         held_q, held_d;
  logic [7:0]   to_q, to_d;
  frame_state_e state_q, state_d;
  logic [3:0]   pend_ones_q, pend_ones_d, pend_tens_q, pend_tens_d;
  logic         pend_ones_err_q, pend_ones_err_d, pend_tens_err_q, pend_tens_err_d;
  logic [3:0]   tens_q, tens_d, ones_q, ones_d;
  logic         tens_err_q, tens_err_d, ones_err_q, ones_err_d;
  logic         fv_q, fv_d, stale_q, stale_d;

  logic [3:0]   dec_code;
  logic         dec_err;
  logic         changed, accept, timeout_hit, is_tens;

  seg7_decode u_dec (
    .pattern_i (seg_q[6:0]),
    .code_o    (dec_code),
    .err_o     (dec_err)
  );

  assign changed     = (bus.seg_in != seg_q);
  assign accept      = (run_q == RUN_MAX) && !held_q;
  assign timeout_hit = (to_q == TO_MAX);
  assign is_tens     = seg_q[7];

  // held_q blocks re-acceptance of a bus value that stays put.
  assign run_d  = changed ? 4'd1 : ((run_q == RUN_MAX) ? run_q : run_q + 4'd1);
  assign held_d = changed ? 1'b0 : (accept ? 1'b1 : held_q);
  assign to_d   = accept ? 8'd0 : (timeout_hit ? to_q : to_q + 8'd1);

  always_comb begin
    state_d         = state_q;
    pend_ones_d     = pend_ones_q;
    pend_ones_err_d = pend_ones_err_q;
    pend_tens_d     = pend_tens_q;
    pend_tens_err_d = pend_tens_err_q;
    tens_d          = tens_q;
    ones_d          = ones_q;
    tens_err_d      = tens_err_q;
    ones_err_d      = ones_err_q;
    fv_d            = 1'b0;
    stale_d         = stale_q;

    if (accept) begin
      stale_d = 1'b0;
      if (is_tens) begin
        if (state_q == HAVE_ONES) begin
          tens_d     = dec_code;
          tens_err_d = dec_err;
          ones_d     = pend_ones_q;
          ones_err_d = pend_ones_err_q;
          fv_d       = 1'b1;
          state_d    = IDLE;
        end else begin
          pend_tens_d     = dec_code;
          pend_tens_err_d = dec_err;
          state_d         = HAVE_TENS;
        end
      end else begin
        if (state_q == HAVE_TENS) begin
          tens_d     = pend_tens_q;
          tens_err_d = pend_tens_err_q;
          ones_d     = dec_code;
          ones_err_d = dec_err;
          fv_d       = 1'b1;
          state_d    = IDLE;
        end else begin
          pend_ones_d     = dec_code;
          pend_ones_err_d = dec_err;
          state_d         = HAVE_ONES;
        end
      end
    end else if (timeout_hit) begin
      stale_d = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q           <= 8'h00;
      run_q           <= 4'd0;
      held_q          <= 1'b0;
      to_q            <= 8'd0;
      state_q         <= IDLE;
      pend_ones_q     <= CODE_BLANK;
      pend_ones_err_q <= 1'b0;
      pend_tens_q     <= CODE_BLANK;
      pend_tens_err_q <= 1'b0;
      tens_q          <= CODE_BLANK;
      ones_q          <= CODE_BLANK;
      tens_err_q      <= 1'b0;
      ones_err_q      <= 1'b0;
      fv_q            <= 1'b0;
      stale_q         <= 1'b0;
    end else begin
      seg_q           <= bus.seg_in;
      run_q           <= run_d;
      held_q          <= held_d;
      to_q            <= to_d;
      state_q         <= state_d;
      pend_ones_q     <= pend_ones_d;
      pend_ones_err_q <= pend_ones_err_d;
      pend_tens_q     <= pend_tens_d;
      pend_tens_err_q <= pend_tens_err_d;
      tens_q          <= tens_d;
      ones_q          <= ones_d;
      tens_err_q      <= tens_err_d;
      ones_err_q      <= ones_err_d;
      fv_q            <= fv_d;
      stale_q         <= stale_d;
    end
  end

  assign bus.tens        = tens_q;
  assign bus.ones        = ones_q;
  assign bus.tens_err    = tens_err_q;
  assign bus.ones_err    = ones_err_q;
  assign bus.frame_valid = fv_q;
  assign bus.stale       = stale_q;

endmodule
